program_loader_ctrl: RTL and testbench
======================================

Name: program_loader_ctrl

Overview:
- Sequences loading of the 32-entry instruction memory from the UART byte stream, replacing the free-running two-byte capture with a framed, checked protocol.
- Sits between the rxuartlite receiver and the instruction memory write port.
- Holds the CPU in stall until a valid image is loaded, and supports reload on request.

Parameters:
- DEPTH, 32, number of 16-bit instruction words.
- ADDR_W, 5, write address width (log2 DEPTH).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1_000_000, max CLK cycles between bytes inside a frame.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe; rx_data valid (rxuartlite o_wr).
- rx_data  in  8  received byte (rxuartlite o_data).
- reload  in  1  one-cycle request to discard the current image and accept a new frame.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- cpu_hold  out  1  high while no valid image is loaded; CPU PC held at 0.
- load_done  out  1  valid image present.
- load_error  out  1  sticky; last frame failed checksum, count or timeout.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0, state=IDLE.
- Frame format: SYNC_BYTE, COUNT, 2*N data bytes (high byte first per word), CSUM.
  - N = COUNT, except COUNT=0 means DEPTH.
  - COUNT>DEPTH is an error.
  - CSUM = XOR of COUNT and all data bytes.
- State machine:
  - IDLE: rx_valid with SYNC_BYTE -> CNT; other bytes are ignored.
  - CNT: on byte, latch N and init xor=byte. Valid N -> HI; N>DEPTH -> ERR.
  - HI: on byte, latch hi, xor^=byte -> LO.
  - LO: on byte, mem_we=1 for exactly one cycle with mem_addr=word index and mem_wdata={hi,byte}; xor^=byte; index+1. When index reaches N -> CSUM, else -> HI.
  - CSUM: byte==xor -> FILL if N<DEPTH, else DONE; mismatch -> ERR.
  - FILL: write 16'h0000 (NOP) to each address N..DEPTH-1, one per cycle, mem_we=1 each cycle; rx bytes ignored; then -> DONE.
  - DONE: load_done=1, cpu_hold=0, load_error=0. Stays until reload.
  - ERR: load_error=1, load_done=0, cpu_hold=1; next cycle -> IDLE to await a new frame.
- Write latency: mem_we asserted the cycle after the rx_valid carrying the low byte. Address and data are registered.
- Words are written as they arrive, so a failed frame leaves memory partially overwritten. cpu_hold therefore stays 1 until DONE.
- Timeout: inter-byte counter resets on every rx_valid and runs in CNT, HI, LO and CSUM. Reaching TIMEOUT -> ERR.
- reload:
  - In DONE: -> IDLE, load_done=0, cpu_hold=1 in the next cycle.
  - In any mid-frame state: restart at IDLE; the partial frame is discarded and load_error is not set.
  - Coinciding with rx_valid: reload wins and the byte is dropped.
- A SYNC_BYTE value inside a frame is treated as data; there is no resync mid-frame.
- Address wrap: the index never exceeds DEPTH-1. The counter is ADDR_W+1 bits so that N=DEPTH terminates correctly.
- RST_N asserted mid-frame or mid-FILL: immediate return to reset values; memory contents are undefined.

Decomposition:
- Shared package/header holds:
  - state encoding constants: IDLE, CNT, HI, LO, CSUM, FILL, DONE, ERR.
  - SYNC_BYTE default.
  - instruction width of 16.
- One sub-module, loader_timeout_counter: a reloadable down-counter with expire pulse, reused by future UART blocks.
- The FSM, word assembly and checksum stay in the top module.

Test Plan:
- Full frame: A5,00, 64 data bytes (word k = 16'h1000+k), correct CSUM -> 32 writes, addr 0..31 with matching data; load_done=1 and cpu_hold=0 one cycle after the CSUM byte.
- Short frame: A5,03, words 1350,D300,104E, CSUM=03^13^50^D3^00^10^4E -> 3 data writes, then 29 FILL writes of 0000 on consecutive cycles at addr 3..31; then DONE.
- Bad checksum: same short frame with CSUM^1 -> load_error=1, load_done=0, cpu_hold=1, no FILL writes; next valid frame clears load_error.
- Count overflow: A5,21 -> ERR immediately, zero writes.
- Timeout: A5,02,12 then silence for TIMEOUT cycles -> ERR; the following A5 is accepted as a new frame start.
- Reload and reset: reload in DONE -> cpu_hold=1 the next cycle; RST_N low during LO -> all outputs at reset values with no further mem_we; stray 00/FF bytes in IDLE -> ignored.

Source files
------------

// File: rtl/program_loader_ctrl_pkg.sv
// Shared definitions for the program loader.
// Holds the loader state encoding, the default frame start marker,
// the default image depth and the instruction word width.
package program_loader_ctrl_pkg;

  localparam int unsigned INSTR_W       = 16;
  localparam int unsigned DEPTH_DEF     = 32;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  // Loader states. ERR lasts one cycle before falling back to IDLE.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CNT  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CSUM = 3'd4,
    FILL = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader_ctrl_timeout.sv
// loader_timeout_counter: reloadable down-counter with expire strobe.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : reload the counter to LOAD_VAL (has priority over en)
//   en         : count down while high
//   expire     : high while enabled, not reloading, and the count is zero
// With LOAD_VAL = T-1, expire rises T cycles after the last load when
// en stays high throughout.
module loader_timeout_counter #(
  parameter int unsigned LOAD_VAL = 999_999,
  localparam int unsigned W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(LOAD_VAL);
    end else if (load) begin
      cnt <= W'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = en && !load && (cnt == '0);

endmodule

// File: rtl/program_loader_ctrl.sv
// program_loader_ctrl: framed loader for the instruction memory.
// Accepts SYNC, COUNT, 2*N data bytes (high byte first), CSUM from the
// UART receiver and writes each word as soon as its low byte arrives.
// Short images are padded with NOP (0000) words up to DEPTH-1.
// Ports:
//   CLK, RST_N : clock and asynchronous active-low reset
//   rx_valid   : one-cycle byte strobe from the UART receiver
//   rx_data    : received byte
//   reload     : one-cycle request to drop the image and await a new frame
//   mem_we     : instruction memory write enable (one cycle per word)
//   mem_addr   : write address
//   mem_wdata  : write data
//   cpu_hold   : high until a complete, checked image is loaded
//   load_done  : a valid image is present
//   load_error : sticky; last frame failed checksum, count or timeout
//   dbg_state  : current loader state
// Handshake: rx_valid is a strobe with no back-pressure; the loader
// consumes every strobed byte in the cycle it is presented (a byte that
// coincides with reload is dropped). mem_we has no ready; the memory
// must accept one write per cycle.
module program_loader_ctrl
  import program_loader_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               reload,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error,
  output state_t             dbg_state
);

  // One extra bit so that a count of DEPTH words can be represented and
  // the final LO byte terminates on idx+1 == DEPTH.
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(DEPTH - 1);
  localparam logic [7:0]       DEPTH_B = 8'(DEPTH);

  state_t           state;
  logic [IDX_W-1:0] n_words;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [7:0]       hi_byte;
  logic [7:0]       xsum;
  logic             tmo_en;
  logic             tmo_expire;

  assign idx_inc   = idx + IDX_W'(1);
  assign dbg_state = state;

  // The inter-byte timer only runs while a frame is in flight.
  always_comb begin
    tmo_en = 1'b0;
    case (state)
      CNT, HI, LO, CSUM: tmo_en = 1'b1;
      default:           tmo_en = 1'b0;
    endcase
  end

  loader_timeout_counter #(
    .LOAD_VAL (TIMEOUT - 1)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST_N),
    .load   (rx_valid),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      n_words    <= '0;
      idx        <= '0;
      hi_byte    <= '0;
      xsum       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (reload) begin
        // Discard whatever is in progress; load_error keeps its value.
        state     <= IDLE;
        load_done <= 1'b0;
        cpu_hold  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state <= CNT;
            end
          end

          CNT: begin
            if (rx_valid) begin
              xsum <= rx_data;
              idx  <= '0;
              if (rx_data == 8'd0) begin
                n_words <= DEPTH_I;
                state   <= HI;
              end else if (rx_data > DEPTH_B) begin
                state      <= ERR;
                load_error <= 1'b1;
                load_done  <= 1'b0;
                cpu_hold   <= 1'b1;
              end else begin
                n_words <= IDX_W'(rx_data);
                state   <= HI;
              end
            end else if (tmo_expire) begin
              state      <= ERR;
              load_error <= 1'b1;
              load_done  <= 1'b0;
              cpu_hold   <= 1'b1;
            end
          end

          HI: begin
            if (rx_valid) begin
              hi_byte <= rx_data;
              xsum    <= xsum ^ rx_data;
              state   <= LO;
            end else if (tmo_expire) begin
              state      <= ERR;
              load_error <= 1'b1;
              load_done  <= 1'b0;
              cpu_hold   <= 1'b1;
            end
          end

          LO: begin
            if (rx_valid) begin
              mem_we    <= 1'b1;
              mem_addr  <= idx[ADDR_W-1:0];
              mem_wdata <= {hi_byte, rx_data};
              xsum      <= xsum ^ rx_data;
              idx       <= idx_inc;
              state     <= (idx_inc == n_words) ? CSUM : HI;
            end else if (tmo_expire) begin
              state      <= ERR;
              load_error <= 1'b1;
              load_done  <= 1'b0;
              cpu_hold   <= 1'b1;
            end
          end

          CSUM: begin
            if (rx_valid) begin
              if (rx_data != xsum) begin
                state      <= ERR;
                load_error <= 1'b1;
                load_done  <= 1'b0;
                cpu_hold   <= 1'b1;
              end else if (n_words < DEPTH_I) begin
                // idx already equals n_words: first pad address.
                state <= FILL;
              end else begin
                state      <= DONE;
                load_done  <= 1'b1;
                cpu_hold   <= 1'b0;
                load_error <= 1'b0;
              end
            end else if (tmo_expire) begin
              state      <= ERR;
              load_error <= 1'b1;
              load_done  <= 1'b0;
              cpu_hold   <= 1'b1;
            end
          end

          FILL: begin
            mem_we    <= 1'b1;
            mem_addr  <= idx[ADDR_W-1:0];
            mem_wdata <= '0;
            idx       <= idx_inc;
            if (idx == LAST_I) begin
              state      <= DONE;
              load_done  <= 1'b1;
              cpu_hold   <= 1'b0;
              load_error <= 1'b0;
            end
          end

          DONE: begin
            load_done  <= 1'b1;
            cpu_hold   <= 1'b0;
            load_error <= 1'b0;
          end

          ERR: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed bench for program_loader_ctrl with a write scoreboard.
module tb_program_loader_ctrl;
  import program_loader_ctrl_pkg::*;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  logic [20:0] exp_q[$];
  logic [20:0] mon_e;
  logic [15:0] full_w[$];
  logic [15:0] short_w[$];

  program_loader_ctrl #(
    .DEPTH     (32),
    .ADDR_W    (5),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TMO)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .reload     (reload),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every memory write must match the head of exp_q.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      writes++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("write_addr_data", {11'd0, mem_addr, mem_wdata}, {11'd0, mon_e});
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Sends a frame and queues the expected data and NOP-fill writes.
  task automatic send_frame(input logic [7:0] cnt, input logic [15:0] w[$], input bit bad);
    logic [7:0] x;
    int n;
    x = cnt;
    n = (cnt == 8'd0) ? 32 : int'(cnt);
    send_byte(8'hA5);
    send_byte(cnt);
    for (int i = 0; i < w.size(); i++) begin
      x = x ^ w[i][15:8] ^ w[i][7:0];
      exp_q.push_back({5'(i), w[i]});
      send_byte(w[i][15:8]);
      send_byte(w[i][7:0]);
    end
    if (!bad) begin
      for (int a = n; a < 32; a++) exp_q.push_back({5'(a), 16'h0000});
    end
    send_byte(bad ? (x ^ 8'h01) : x);
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    for (int i = 0; i < 32; i++) full_w.push_back(16'h1000 + 16'(i));
    short_w.push_back(16'h1350);
    short_w.push_back(16'hD300);
    short_w.push_back(16'h104E);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Stray bytes in IDLE are ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (2) @(negedge clk);
    check("stray_state", 32'(dbg_state), 32'(IDLE));
    check("stray_hold", 32'(cpu_hold), 32'd1);
    check("stray_writes", 32'(writes), 32'd0);

    // Full 32-word frame
    send_frame(8'h00, full_w, 1'b0);
    check("full_done", 32'(load_done), 32'd1);
    check("full_hold", 32'(cpu_hold), 32'd0);
    check("full_err", 32'(load_error), 32'd0);
    repeat (2) @(negedge clk);
    check("full_writes", 32'(writes), 32'd32);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Reload from DONE
    pulse_reload();
    check("reload_hold", 32'(cpu_hold), 32'd1);
    check("reload_done", 32'(load_done), 32'd0);
    check("reload_state", 32'(dbg_state), 32'(IDLE));

    // Short frame with NOP fill on consecutive cycles
    send_frame(8'h03, short_w, 1'b0);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      check("fill_we", 32'(mem_we), 32'd1);
    end
    check("short_done", 32'(load_done), 32'd1);
    check("short_hold", 32'(cpu_hold), 32'd0);
    repeat (2) @(negedge clk);
    check("short_writes", 32'(writes), 32'd64);
    check("short_q_empty", 32'(exp_q.size()), 32'd0);
    pulse_reload();

    // Bad checksum: error, no fill
    send_frame(8'h03, short_w, 1'b1);
    check("bad_err", 32'(load_error), 32'd1);
    check("bad_done", 32'(load_done), 32'd0);
    check("bad_hold", 32'(cpu_hold), 32'd1);
    repeat (5) @(negedge clk);
    check("bad_writes", 32'(writes), 32'd67);
    check("bad_q_empty", 32'(exp_q.size()), 32'd0);

    // Next valid frame clears load_error
    send_frame(8'h03, short_w, 1'b0);
    repeat (31) @(negedge clk);
    check("recover_done", 32'(load_done), 32'd1);
    check("recover_err", 32'(load_error), 32'd0);
    check("recover_writes", 32'(writes), 32'd99);
    pulse_reload();

    // Timeout in LO after A5,02,12
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_yet", 32'(dbg_state), 32'(LO));
    check("tmo_err_clear", 32'(load_error), 32'd0);
    k = 0;
    while ((dbg_state !== ERR) && (k < 10)) begin
      @(negedge clk);
      k++;
    end
    check("tmo_state_err", 32'(dbg_state), 32'(ERR));
    check("tmo_latency", 32'(k), 32'd2);
    check("tmo_err", 32'(load_error), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);

    // Following A5 starts a new frame; COUNT=0x21 overflows
    send_byte(8'hA5);
    check("resync_cnt", 32'(dbg_state), 32'(CNT));
    send_byte(8'h21);
    check("ovf_state", 32'(dbg_state), 32'(ERR));
    check("ovf_err", 32'(load_error), 32'd1);
    repeat (2) @(negedge clk);
    check("ovf_idle", 32'(dbg_state), 32'(IDLE));
    check("ovf_writes", 32'(writes), 32'd99);

    // Reset asserted while in LO
    exp_q.push_back({5'd0, 16'h1234});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    check("pre_rst_state", 32'(dbg_state), 32'(LO));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_we", 32'(mem_we), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_wdata", 32'(mem_wdata), 32'd0);
    check("mrst_hold", 32'(cpu_hold), 32'd1);
    check("mrst_done", 32'(load_done), 32'd0);
    check("mrst_err", 32'(load_error), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mrst_writes", 32'(writes), 32'd100);
    check("mrst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
